ltssm_config_ctrl: RTL and testbench
====================================

Name: ltssm_config_ctrl

Overview:
- Parametrised Configuration-state controller for the PCIe LTSSM, for N lanes.
- Runs the full sub-state sequence: Linkwidth.Start/Accept, Lanenum.Wait/Accept, Complete, Idle.
- Resolves the link width, requests TS1/TS2/Idle ordered-set transmission and enforces spec minimum counts and timeouts.
- Sits between the per-lane ordered-set decoders and the TX ordered-set generator; reports pass/fail to the top-level LTSSM.

Parameters:
- MAX_NUM_LANES, 4, lanes supported; power of two, 1..16.
- LINK_NUM, 0, link number advertised in TS1/TS2.
- TIMEOUT_LONG_CYC, 6000000, Linkwidth.Start timeout (24 ms at 250 MHz).
- TIMEOUT_SHORT_CYC, 500000, Lanenum.Wait/Complete/Idle timeout (2 ms).
- TS2_RX_MIN, 8, consecutive TS2 required per active lane.
- TS2_TX_MIN, 16, TS2 sent after the first TS2 is received.
- IDLE_RX_MIN, 8, consecutive idle symbols required per active lane.
- IDLE_TX_MIN, 16, idle symbols sent after the first idle is received.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  LTSSM is in Configuration; low aborts to S_IDLE.
- lane_detected_i  in  N  lanes detected in Detect/Polling.
- rx_ts1_link_i  in  N  pulse: TS1 received with link number == LINK_NUM.
- rx_ts1_lane_i  in  N  pulse: TS1 received with lane number == own lane index.
- rx_ts2_i  in  N  pulse: matching TS2 received.
- rx_idle_i  in  N  level: idle symbol received this cycle.
- tx_os_type_o  out  2  0 NONE, 1 TS1, 2 TS2, 3 IDLE.
- tx_link_pad_o  out  1  send PAD in the link field.
- tx_lane_pad_o  out  N  send PAD in the lane field, per lane.
- tx_os_valid_o  out  1  transmit request.
- tx_os_ready_i  in  1  one OS/idle symbol consumed.
- link_width_o  out  5  resolved width: 0, 1, 2, 4, 8 or 16.
- active_lanes_o  out  N  mask of lanes 0..W-1.
- success_o  out  1  Configuration completed.
- error_o  out  1  timeout or no usable width.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset values: state S_IDLE; all outputs 0; link_width_o=0; counters and timer cleared.
- en_i low in any state: S_IDLE on the next cycle; counters and latched width cleared.
- The timer clears on every state entry. It saturates and does not wrap.
- The request interface is level-based. tx_os_valid_o=1 in every transmit state. tx_os_type_o may change on any state change. tx_os_ready_i is counted only when valid is high.
- S_IDLE:
  - Outputs NONE.
  - en_i high -> S_LW_START.
- S_LW_START:
  - TS1, link=LINK_NUM, all lanes PAD.
  - Any set bit of (rx_ts1_link_i & lane_detected_i) -> S_LW_ACCEPT.
  - Timer==TIMEOUT_LONG_CYC-1 -> S_FAIL.
  - If both happen in the same cycle, the advance wins.
- S_LW_ACCEPT (1 cycle):
  - Latch the received mask M (accumulated over S_LW_START).
  - W = the largest power of two ≤ N such that lanes 0..W-1 are all set in M.
  - W=0 -> S_FAIL. Otherwise latch link_width_o and active_lanes_o and go to S_LN_WAIT.
- S_LN_WAIT:
  - TS1, lane numbers on active lanes, PAD on the others.
  - Sticky per-lane flags from rx_ts1_lane_i; all active lanes set -> S_LN_ACCEPT.
  - Short timeout -> S_FAIL.
- S_LN_ACCEPT:
  - One cycle, then S_COMPLETE.
- S_COMPLETE:
  - Sends TS2.
  - Per-lane counters count rx_ts2_i pulses, saturating at TS2_RX_MIN. An rx_ts1_link_i pulse on a lane clears that lane's counter (non-consecutive).
  - The TX counter counts accepted TS2 once any active lane has received a TS2, saturating at TS2_TX_MIN.
  - All active lane counters == TS2_RX_MIN and TX counter == TS2_TX_MIN -> S_CFG_IDLE.
  - Short timeout -> S_FAIL.
- S_CFG_IDLE:
  - Sends IDLE.
  - Per-lane consecutive counters increment while rx_idle_i is high and clear when it is low.
  - The TX idle counter starts on the first received idle.
  - All active lanes ≥ IDLE_RX_MIN and TX counter ≥ IDLE_TX_MIN -> S_SUCCESS.
  - Short timeout -> S_FAIL.
- S_SUCCESS:
  - success_o=1 and NONE; held until en_i low.
  - link_width_o holds its value.
- S_FAIL:
  - error_o=1 and NONE; held until en_i low.
- Inactive lanes are ignored for every completion condition.
- Latency: en_i rise to the first TS1 request is 1 cycle.

Decomposition:
- ltssm_pkg holds:
  - os_type_e {OS_NONE, OS_TS1, OS_TS2, OS_IDLE}.
  - cfg_state_e.
  - the width-resolve function.
- Sub-module ltssm_lane_counter (parameter MAX; ports inc, clr, sat_o) holds one per-lane saturating consecutive counter. It is instantiated N times for TS2 and N times for idle.

Test Plan (N=4, TIMEOUT_LONG=200, TIMEOUT_SHORT=50, minimum counts at defaults, tx_os_ready_i=1):
- Full x4 success: all lanes see TS1 link, then TS1 lane, then 8 TS2 and 8+ idles.
  - Required: link_width_o=4, active_lanes_o=4'hF, TS1 -> TS2 -> IDLE sequence, success_o=1.
  - TX TS2 count ≥16 before IDLE.
- Width down-train: the TS1 link mask is 4'b1011.
  - Required: W=2, active_lanes_o=4'h3, tx_lane_pad_o=4'b1100.
  - Lanes 2/3 are ignored and the sequence still succeeds.
- Linkwidth timeout: no rx_ts1_link_i.
  - Required: S_FAIL at 200 cycles after entry, error_o=1, success_o=0.
- TS2 consecutiveness: lane 1 receives 5 TS2, then a TS1, then 8 TS2.
  - Required: exit from S_COMPLETE is delayed until lane 1's 8th TS2 after the TS1.
- Idle gap: lane 0 idle stream drops low for 1 cycle at count 6.
  - Required: the count restarts, and success requires 8 further consecutive idles.
- Abort/reset: en_i low mid-S_COMPLETE, or rst_i asserted asynchronously.
  - Required: S_IDLE and all outputs 0 immediately (reset) or next cycle (en_i low).
  - Re-enable restarts at S_LW_START.

Source files
------------

// File: rtl/ltssm_pkg.sv
// Shared types and helpers for the LTSSM Configuration controller.
// Holds ordered-set codes, controller states and the link-width resolver.
package ltssm_pkg;

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_TS1  = 2'd1,
        OS_TS2  = 2'd2,
        OS_IDLE = 2'd3
    } os_type_e;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LW_START  = 4'd1,
        S_LW_ACCEPT = 4'd2,
        S_LN_WAIT   = 4'd3,
        S_LN_ACCEPT = 4'd4,
        S_COMPLETE  = 4'd5,
        S_CFG_IDLE  = 4'd6,
        S_SUCCESS   = 4'd7,
        S_FAIL      = 4'd8
    } cfg_state_e;

    // Largest power-of-two width <= n whose lanes 0..w-1 are all present
    function automatic logic [4:0] resolve_width(
        input logic [15:0] mask,
        input int unsigned n
    );
        logic [4:0]  w;
        logic [15:0] low;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            low = 16'((32'd1 << (32'd1 << k)) - 32'd1);
            if (((32'd1 << k) <= n) && ((mask & low) == low)) begin
                w = 5'(32'd1 << k);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ltssm_lane_counter.sv
// Per-lane saturating counter of consecutive events.
// clr has priority over inc; sat_o flags that MAX has been reached.
module ltssm_lane_counter #(
    parameter int unsigned MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,
    input  logic clr,
    output logic sat_o
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    // Count up to MAX, restart whenever the run is broken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign sat_o = (r_cnt == W'(MAX));

endmodule

// File: rtl/ltssm_config_ctrl.sv
// PCIe LTSSM Configuration sub-state controller for N lanes.
// Negotiates width, drives TS1/TS2/IDLE requests, reports pass/fail.
module ltssm_config_ctrl #(
    parameter int unsigned MAX_NUM_LANES     = 4,
    parameter int unsigned LINK_NUM          = 0,
    parameter int unsigned TIMEOUT_LONG_CYC  = 6000000,
    parameter int unsigned TIMEOUT_SHORT_CYC = 500000,
    parameter int unsigned TS2_RX_MIN        = 8,
    parameter int unsigned TS2_TX_MIN        = 16,
    parameter int unsigned IDLE_RX_MIN       = 8,
    parameter int unsigned IDLE_TX_MIN       = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [MAX_NUM_LANES-1:0] lane_detected_i,
    input  logic [MAX_NUM_LANES-1:0] rx_ts1_link_i,
    input  logic [MAX_NUM_LANES-1:0] rx_ts1_lane_i,
    input  logic [MAX_NUM_LANES-1:0] rx_ts2_i,
    input  logic [MAX_NUM_LANES-1:0] rx_idle_i,
    output logic [1:0]               tx_os_type_o,
    output logic                     tx_link_pad_o,
    output logic [MAX_NUM_LANES-1:0] tx_lane_pad_o,
    output logic                     tx_os_valid_o,
    input  logic                     tx_os_ready_i,
    output logic [4:0]               link_width_o,
    output logic [MAX_NUM_LANES-1:0] active_lanes_o,
    output logic                     success_o,
    output logic                     error_o,
    output logic [3:0]               state_o
);

    import ltssm_pkg::*;

    localparam int unsigned N = MAX_NUM_LANES;
    localparam logic [31:0] LONG_LAST  = 32'(TIMEOUT_LONG_CYC - 1);
    localparam logic [31:0] SHORT_LAST = 32'(TIMEOUT_SHORT_CYC - 1);
    // A link number that does not fit the 8-bit field is sent as PAD
    localparam logic LINK_PAD = (LINK_NUM > 255);

    cfg_state_e  r_state;
    cfg_state_e  w_next;
    os_type_e    w_os_type;
    logic [31:0] r_timer;
    logic [N-1:0] r_rx_mask;
    logic [N-1:0] r_ln_seen;
    logic [N-1:0] r_active;
    logic [4:0]   r_width;
    logic         r_rx_started;
    logic [15:0]  r_tx_cnt;

    logic [4:0]   w_res_width;
    logic [N-1:0] w_res_mask;
    logic [N-1:0] w_ln_seen;
    logic [N-1:0] w_ts2_inc, w_ts2_clr, w_ts2_sat;
    logic [N-1:0] w_idle_inc, w_idle_clr, w_idle_sat;
    logic         w_in_cpl, w_in_idl;
    logic         w_lw_hit, w_long_to, w_short_to;
    logic         w_ts2_done, w_idle_done;
    logic         w_rx_first, w_started, w_accept;
    logic [15:0]  w_tx_lim;
    logic         w_tx_done;

    assign w_in_cpl    = (r_state == S_COMPLETE);
    assign w_in_idl    = (r_state == S_CFG_IDLE);
    assign w_lw_hit    = |(rx_ts1_link_i & lane_detected_i);
    assign w_long_to   = (r_timer == LONG_LAST);
    assign w_short_to  = (r_timer == SHORT_LAST);
    assign w_res_width = resolve_width(16'(r_rx_mask), N);
    assign w_ln_seen   = r_ln_seen | (rx_ts1_lane_i & r_active);

    assign w_ts2_inc  = rx_ts2_i & {N{w_in_cpl}};
    assign w_ts2_clr  = rx_ts1_link_i | {N{!en_i || !w_in_cpl}};
    assign w_idle_inc = rx_idle_i & {N{w_in_idl}};
    assign w_idle_clr = ~rx_idle_i | {N{!en_i || !w_in_idl}};

    assign w_ts2_done  = &(w_ts2_sat | ~r_active);
    assign w_idle_done = &(w_idle_sat | ~r_active);

    assign w_rx_first = w_in_cpl ? |(rx_ts2_i & r_active) :
                        w_in_idl ? |(rx_idle_i & r_active) : 1'b0;
    assign w_started  = r_rx_started | w_rx_first;
    assign w_accept   = tx_os_valid_o & tx_os_ready_i;
    assign w_tx_lim   = w_in_cpl ? 16'(TS2_TX_MIN) : 16'(IDLE_TX_MIN);
    assign w_tx_done  = (r_tx_cnt >= w_tx_lim);

    for (genvar g = 0; g < N; g++) begin : g_lane
        ltssm_lane_counter #(.MAX(TS2_RX_MIN)) u_ts2 (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (w_ts2_inc[g]),
            .clr   (w_ts2_clr[g]),
            .sat_o (w_ts2_sat[g])
        );
        ltssm_lane_counter #(.MAX(IDLE_RX_MIN)) u_idle (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (w_idle_inc[g]),
            .clr   (w_idle_clr[g]),
            .sat_o (w_idle_sat[g])
        );
    end

    // Lane mask 0..W-1 for the width being resolved
    always_comb begin
        w_res_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_res_mask[i] = (5'(i) < w_res_width);
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a completed condition beats a same-cycle timeout
    always_comb begin
        w_next = r_state;
        if (!en_i) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:      w_next = S_LW_START;
                S_LW_START: begin
                    if (w_lw_hit)       w_next = S_LW_ACCEPT;
                    else if (w_long_to) w_next = S_FAIL;
                end
                S_LW_ACCEPT: begin
                    w_next = (w_res_width == '0) ? S_FAIL : S_LN_WAIT;
                end
                S_LN_WAIT: begin
                    if ((w_ln_seen & r_active) == r_active) w_next = S_LN_ACCEPT;
                    else if (w_short_to)                    w_next = S_FAIL;
                end
                S_LN_ACCEPT: w_next = S_COMPLETE;
                S_COMPLETE: begin
                    if (w_ts2_done && w_tx_done) w_next = S_CFG_IDLE;
                    else if (w_short_to)         w_next = S_FAIL;
                end
                S_CFG_IDLE: begin
                    if (w_idle_done && w_tx_done) w_next = S_SUCCESS;
                    else if (w_short_to)          w_next = S_FAIL;
                end
                S_SUCCESS:   w_next = S_SUCCESS;
                S_FAIL:      w_next = S_FAIL;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        w_os_type     = OS_NONE;
        tx_os_valid_o = 1'b0;
        tx_link_pad_o = 1'b0;
        tx_lane_pad_o = '0;
        success_o     = 1'b0;
        error_o       = 1'b0;
        unique case (r_state)
            S_LW_START, S_LW_ACCEPT: begin
                w_os_type     = OS_TS1;
                tx_os_valid_o = 1'b1;
                tx_link_pad_o = LINK_PAD;
                tx_lane_pad_o = '1;
            end
            S_LN_WAIT, S_LN_ACCEPT: begin
                w_os_type     = OS_TS1;
                tx_os_valid_o = 1'b1;
                tx_link_pad_o = LINK_PAD;
                tx_lane_pad_o = ~r_active;
            end
            S_COMPLETE: begin
                w_os_type     = OS_TS2;
                tx_os_valid_o = 1'b1;
                tx_link_pad_o = LINK_PAD;
                tx_lane_pad_o = ~r_active;
            end
            S_CFG_IDLE: begin
                w_os_type     = OS_IDLE;
                tx_os_valid_o = 1'b1;
            end
            S_SUCCESS:  success_o = 1'b1;
            S_FAIL:     error_o   = 1'b1;
            default: begin
                w_os_type = OS_NONE;
            end
        endcase
    end

    assign tx_os_type_o   = w_os_type;
    assign link_width_o   = r_width;
    assign active_lanes_o = r_active;
    assign state_o        = r_state;

    // Per-state timer: restarts on every transition, sticks at all-ones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer <= '0;
        end else if (w_next != r_state) begin
            r_timer <= '0;
        end else if (r_timer != '1) begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Collect lanes that reported our link number, then latch the width
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_mask <= '0;
            r_width   <= '0;
            r_active  <= '0;
        end else if (!en_i || (r_state == S_IDLE)) begin
            r_rx_mask <= '0;
            r_width   <= '0;
            r_active  <= '0;
        end else if (r_state == S_LW_START) begin
            r_rx_mask <= r_rx_mask | (rx_ts1_link_i & lane_detected_i);
        end else if ((r_state == S_LW_ACCEPT) && (w_res_width != '0)) begin
            r_width  <= w_res_width;
            r_active <= w_res_mask;
        end
    end

    // Sticky lane-number acknowledgements while waiting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ln_seen <= '0;
        end else if (!en_i || (r_state != S_LN_WAIT)) begin
            r_ln_seen <= '0;
        end else begin
            r_ln_seen <= w_ln_seen;
        end
    end

    // TX count of TS2/idle sent after the partner first answers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_started <= 1'b0;
            r_tx_cnt     <= '0;
        end else if (!en_i || (w_next != r_state)) begin
            r_rx_started <= 1'b0;
            r_tx_cnt     <= '0;
        end else if (w_in_cpl || w_in_idl) begin
            r_rx_started <= w_started;
            if (w_started && w_accept && (r_tx_cnt < w_tx_lim)) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ltssm_config_ctrl.sv
// Directed bench for ltssm_config_ctrl (x4, short timeouts).
// Table vectors for the handshake prefix, loops for multi-cycle cases.
module tb_ltssm_config_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] det, lnk, lan, ts2, idl;
    logic       rdy;

    logic [1:0] os_type;
    logic       link_pad;
    logic [3:0] lane_pad;
    logic       os_valid;
    logic [4:0] width;
    logic [3:0] active;
    logic       succ;
    logic       err;
    logic [3:0] st;

    ltssm_config_ctrl #(
        .MAX_NUM_LANES     (4),
        .LINK_NUM          (0),
        .TIMEOUT_LONG_CYC  (200),
        .TIMEOUT_SHORT_CYC (50),
        .TS2_RX_MIN        (8),
        .TS2_TX_MIN        (16),
        .IDLE_RX_MIN       (8),
        .IDLE_TX_MIN       (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .lane_detected_i (det),
        .rx_ts1_link_i   (lnk),
        .rx_ts1_lane_i   (lan),
        .rx_ts2_i        (ts2),
        .rx_idle_i       (idl),
        .tx_os_type_o    (os_type),
        .tx_link_pad_o   (link_pad),
        .tx_lane_pad_o   (lane_pad),
        .tx_os_valid_o   (os_valid),
        .tx_os_ready_i   (rdy),
        .link_width_o    (width),
        .active_lanes_o  (active),
        .success_o       (succ),
        .error_o         (err),
        .state_o         (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] det;
        logic [3:0] lnk;
        logic [3:0] lan;
        logic [3:0] st;
        logic [1:0] ty;
        logic       vl;
        logic [3:0] lp;
        logic [4:0] wd;
        logic [3:0] ac;
    } vec_t;

    vec_t vt [14];
    int   total = 0;
    int   bad   = 0;
    int   n2;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic e, input logic [3:0] d, input logic [3:0] l1,
                       input logic [3:0] l2, input logic [3:0] t2, input logic [3:0] id);
        en  = e;
        det = d;
        lnk = l1;
        lan = l2;
        ts2 = t2;
        idl = id;
        tick();
    endtask

    task automatic apply(input int i);
        drv(vt[i].en, vt[i].det, vt[i].lnk, vt[i].lan, 4'h0, 4'h0);
        chk($sformatf("v%0d_state", i), 32'(st), 32'(vt[i].st));
        chk($sformatf("v%0d_type", i), 32'(os_type), 32'(vt[i].ty));
        chk($sformatf("v%0d_valid", i), 32'(os_valid), 32'(vt[i].vl));
        chk($sformatf("v%0d_lanepad", i), 32'(lane_pad), 32'(vt[i].lp));
        chk($sformatf("v%0d_width", i), 32'(width), 32'(vt[i].wd));
        chk($sformatf("v%0d_active", i), 32'(active), 32'(vt[i].ac));
    endtask

    task automatic goto_complete();
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("goto_complete", 32'(st), 32'd5);
    endtask

    initial begin
        //        en    det    lnk    lan    st     ty     vl    lp     wd     ac
        vt[0]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'd0, 2'd0, 1'b0, 4'h0, 5'd0, 4'h0};
        vt[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'd1, 2'd1, 1'b1, 4'hF, 5'd0, 4'h0};
        vt[2]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'd2, 2'd1, 1'b1, 4'hF, 5'd0, 4'h0};
        vt[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'd3, 2'd1, 1'b1, 4'h0, 5'd4, 4'hF};
        vt[4]  = '{1'b1, 4'hF, 4'h0, 4'hF, 4'd4, 2'd1, 1'b1, 4'h0, 5'd4, 4'hF};
        vt[5]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'd5, 2'd2, 1'b1, 4'h0, 5'd4, 4'hF};
        vt[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'd0, 2'd0, 1'b0, 4'h0, 5'd0, 4'h0};
        vt[7]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'd1, 2'd1, 1'b1, 4'hF, 5'd0, 4'h0};
        vt[8]  = '{1'b1, 4'h7, 4'h8, 4'h0, 4'd1, 2'd1, 1'b1, 4'hF, 5'd0, 4'h0};
        vt[9]  = '{1'b1, 4'hF, 4'hB, 4'h0, 4'd2, 2'd1, 1'b1, 4'hF, 5'd0, 4'h0};
        vt[10] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'd3, 2'd1, 1'b1, 4'hC, 5'd2, 4'h3};
        vt[11] = '{1'b1, 4'hF, 4'h0, 4'h1, 4'd3, 2'd1, 1'b1, 4'hC, 5'd2, 4'h3};
        vt[12] = '{1'b1, 4'hF, 4'h0, 4'h2, 4'd4, 2'd1, 1'b1, 4'hC, 5'd2, 4'h3};
        vt[13] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'd5, 2'd2, 1'b1, 4'hC, 5'd2, 4'h3};

        rst = 1'b1; en = 1'b0; rdy = 1'b1;
        det = '0; lnk = '0; lan = '0; ts2 = '0; idl = '0;
        #12;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_valid", 32'(os_valid), 32'd0);
        chk("rst_width", 32'(width), 32'd0);
        chk("rst_flags", 32'({succ, err, os_type}), 32'd0);
        #1 rst = 1'b0;

        // Full x4 negotiation
        for (int i = 0; i <= 5; i++) apply(i);
        n2 = 0;
        for (int i = 0; i <= 16; i++) begin
            if (os_valid && rdy && os_type == 2'd2) n2++;
            drv(1'b1, 4'hF, 4'h0, 4'h0, (i < 8) ? 4'hF : 4'h0, 4'h0);
            if (i == 15) chk("x4_cpl_hold", 32'(st), 32'd5);
            if (i == 16) chk("x4_cpl_exit", 32'(st), 32'd6);
        end
        chk("x4_ts2_sent_ge16", 32'(n2 >= 16), 32'd1);
        chk("x4_idle_type", 32'(os_type), 32'd3);
        for (int j = 0; j <= 16; j++) begin
            drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
            if (j == 15) chk("x4_idle_hold", 32'(st), 32'd6);
            if (j == 16) chk("x4_idle_exit", 32'(st), 32'd7);
        end
        chk("x4_success", 32'({succ, err}), 32'b10);
        chk("x4_width", 32'(width), 32'd4);
        chk("x4_active", 32'(active), 32'hF);
        chk("x4_none", 32'({os_valid, os_type}), 32'd0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("x4_success_hold", 32'(st), 32'd7);

        // Down-train to x2
        for (int i = 6; i <= 13; i++) apply(i);
        for (int i = 0; i <= 16; i++) begin
            drv(1'b1, 4'hF, 4'h0, 4'h0, (i < 8) ? 4'h3 : 4'h0, 4'h0);
            if (i == 16) chk("x2_cpl_exit", 32'(st), 32'd6);
        end
        for (int j = 0; j <= 16; j++) begin
            drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h3);
            if (j == 16) chk("x2_idle_exit", 32'(st), 32'd7);
        end
        chk("x2_success", 32'(succ), 32'd1);
        chk("x2_width", 32'(width), 32'd2);

        // Linkwidth timeout
        drv(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 199; i++) drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("lw_to_hold", 32'(st), 32'd1);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("lw_to_fail", 32'(st), 32'd8);
        chk("lw_to_flags", 32'({succ, err}), 32'b01);
        chk("lw_to_none", 32'({os_valid, os_type}), 32'd0);

        // Advance beats timeout in the same cycle
        drv(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 199; i++) drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        chk("lw_race_advance", 32'(st), 32'd2);

        // TS2 run on lane 1 broken by a TS1
        drv(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        goto_complete();
        for (int i = 0; i <= 19; i++) begin
            drv(1'b1, 4'hF, (i == 10) ? 4'h2 : 4'h0, 4'h0,
                {(i < 8), (i < 8), (i < 5) || (i >= 11 && i <= 18), (i < 8)}, 4'h0);
            if (i == 18) chk("ts2_consec_hold", 32'(st), 32'd5);
            if (i == 19) chk("ts2_consec_exit", 32'(st), 32'd6);
        end

        // Idle run on lane 0 broken for one cycle at count 6
        for (int j = 0; j <= 19; j++) begin
            drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0,
                {3'b111, (j >= 4 && j <= 9) || (j >= 11)});
            if (j == 18) chk("idle_gap_hold", 32'(st), 32'd6);
            if (j == 19) chk("idle_gap_exit", 32'(st), 32'd7);
        end

        // Abort mid-Complete, then restart
        drv(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        goto_complete();
        for (int i = 0; i < 3; i++) drv(1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        drv(1'b0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        chk("abort_state", 32'(st), 32'd0);
        chk("abort_outs", 32'({os_type, os_valid, link_pad, lane_pad, succ, err}), 32'd0);
        chk("abort_width", 32'({width, active}), 32'd0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("abort_restart", 32'({st, os_type, os_valid}), 32'({4'd1, 2'd1, 1'b1}));

        // Asynchronous reset mid Lanenum.Wait
        drv(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("arst_pre", 32'(st), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(st), 32'd0);
        chk("arst_outs", 32'({os_type, os_valid, lane_pad, width, active}), 32'd0);
        #1 rst = 1'b0;
        drv(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("arst_restart", 32'(st), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
